// File: rtl/decode_writeback.sv
// Y86-64 decode stage: register file with writeback port, operand select and the E pipe registers.
// Optional macro DECODE_FWD_EN enables E/M/W operand forwarding; without it d_hazard requests stalls.
module decode_writeback #(
    parameter int         NREGS    = 15,
    parameter logic [3:0] RSP_ID   = 4'd4,
    parameter logic [3:0] STAT_AOK = 4'h8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_ifun,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valC,
    input  logic [63:0] D_valP,
    input  logic [3:0]  D_stat,
    input  logic        E_bubble,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] M_valE,
    input  logic [63:0] m_valM,
    input  logic [3:0]  W_dstE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valE,
    input  logic [63:0] W_valM,
    input  logic [3:0]  W_stat,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [3:0]  E_stat,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic        d_loaduse,
    output logic        d_hazard
);

    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  stat;
        logic [63:0] valC;
        logic [63:0] valA;
        logic [63:0] valB;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
    } ereg_t;

    localparam ereg_t E_BUBBLE = '{icode: I_NOP, ifun: 4'h0, stat: STAT_AOK,
                                   valC: 64'd0, valA: 64'd0, valB: 64'd0,
                                   dstE: RNONE, dstM: RNONE, srcA: RNONE, srcB: RNONE};

    logic [63:0] regs_q [NREGS];
    ereg_t       ex_q;
    ereg_t       ex_d;
    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic [63:0] rf_a;
    logic [63:0] rf_b;
    logic [63:0] opnd_a;
    logic [63:0] opnd_b;
    logic [63:0] d_valA;

    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        d_dstE = RNONE;
        d_dstM = RNONE;
        case (D_icode)
            I_RRMOVQ: begin d_srcA = D_rA; d_dstE = D_rB; end
            I_IRMOVQ: d_dstE = D_rB;
            I_RMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB; end
            I_MRMOVQ: begin d_srcB = D_rB; d_dstM = D_rA; end
            I_OPQ:    begin d_srcA = D_rA; d_srcB = D_rB; d_dstE = D_rB; end
            I_CALL:   begin d_srcB = RSP_ID; d_dstE = RSP_ID; end
            I_RET:    begin d_srcA = RSP_ID; d_srcB = RSP_ID; d_dstE = RSP_ID; end
            I_PUSHQ:  begin d_srcA = D_rA; d_srcB = RSP_ID; d_dstE = RSP_ID; end
            I_POPQ:   begin
                d_srcA = RSP_ID;
                d_srcB = RSP_ID;
                d_dstE = RSP_ID;
                d_dstM = D_rA;
            end
            default: ;
        endcase
    end

    assign rf_a = (d_srcA == RNONE) ? 64'd0 : regs_q[d_srcA];
    assign rf_b = (d_srcB == RNONE) ? 64'd0 : regs_q[d_srcB];

`ifdef DECODE_FWD_EN
    // Youngest producer first; a W-stage write this cycle is seen here, not in the array.
    function automatic logic [63:0] fwd_pick(input logic [3:0] src, input logic [63:0] rf_val);
        if (src == RNONE)  return rf_val;
        if (src == e_dstE) return e_valE;
        if (src == M_dstM) return m_valM;
        if (src == M_dstE) return M_valE;
        if (src == W_dstM) return W_valM;
        if (src == W_dstE) return W_valE;
        return rf_val;
    endfunction

    always_comb begin
        opnd_a = fwd_pick(d_srcA, rf_a);
        opnd_b = fwd_pick(d_srcB, rf_b);
    end

    assign d_hazard = 1'b0;
`else
    function automatic logic dst_busy(input logic [3:0] src);
        return (src != RNONE) &&
               (src == ex_q.dstE || src == ex_q.dstM || src == M_dstE ||
                src == M_dstM || src == W_dstE || src == W_dstM);
    endfunction

    logic unused_fwd;
    assign unused_fwd = ^{e_dstE, e_valE, M_valE, m_valM};

    assign opnd_a   = rf_a;
    assign opnd_b   = rf_b;
    assign d_hazard = dst_busy(d_srcA) || dst_busy(d_srcB);
`endif

    assign d_valA = (D_icode == I_JXX || D_icode == I_CALL) ? D_valP : opnd_a;

    assign d_loaduse = (ex_q.icode == I_MRMOVQ || ex_q.icode == I_POPQ) &&
                       (ex_q.dstM != RNONE) &&
                       (ex_q.dstM == d_srcA || ex_q.dstM == d_srcB);

    always_comb begin
        ex_d = E_BUBBLE;
        if (!E_bubble) begin
            ex_d.icode = D_icode;
            ex_d.ifun  = D_ifun;
            ex_d.stat  = D_stat;
            ex_d.valC  = D_valC;
            ex_d.valA  = d_valA;
            ex_d.valB  = opnd_b;
            ex_d.dstE  = d_dstE;
            ex_d.dstM  = d_dstM;
            ex_d.srcA  = d_srcA;
            ex_d.srcB  = d_srcB;
        end
    end

    // D -> E pipe register boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q <= E_BUBBLE;
        end else begin
            ex_q <= ex_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= 64'd0;
        end else if (W_stat == STAT_AOK) begin
            if (W_dstE != RNONE) regs_q[W_dstE] <= W_valE;
            // Later assignment wins: popq %rsp keeps the loaded value, not the incremented one.
            if (W_dstM != RNONE) regs_q[W_dstM] <= W_valM;
        end
    end

    assign E_icode = ex_q.icode;
    assign E_ifun  = ex_q.ifun;
    assign E_stat  = ex_q.stat;
    assign E_valC  = ex_q.valC;
    assign E_valA  = ex_q.valA;
    assign E_valB  = ex_q.valB;
    assign E_dstE  = ex_q.dstE;
    assign E_dstM  = ex_q.dstM;
    assign E_srcA  = ex_q.srcA;
    assign E_srcB  = ex_q.srcB;

endmodule

// File: tb/tb_decode_writeback.sv
// Self-checking bench for decode_writeback: directed scenarios plus randomized traffic
// compared against a table-level reference model of decode, forwarding and writeback.
module tb_decode_writeback;

    localparam logic [3:0] F = 4'hF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, E_bubble;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB, D_stat;
    logic [63:0] D_valC, D_valP;
    logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM, W_stat;
    logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
    logic [3:0]  E_icode, E_ifun, E_stat, E_dstE, E_dstM, E_srcA, E_srcB, d_srcA, d_srcB;
    logic [63:0] E_valC, E_valA, E_valB;
    logic        d_loaduse, d_hazard;

    decode_writeback dut (
        .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA),
        .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP), .D_stat(D_stat), .E_bubble(E_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_valE(M_valE),
        .m_valM(m_valM), .W_dstE(W_dstE), .W_dstM(W_dstM), .W_valE(W_valE), .W_valM(W_valM),
        .W_stat(W_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat), .E_valC(E_valC),
        .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA),
        .E_srcB(E_srcB), .d_srcA(d_srcA), .d_srcB(d_srcB), .d_loaduse(d_loaduse),
        .d_hazard(d_hazard)
    );

    int n_pass = 0;
    int n_total = 0;

    logic [63:0] mR [15];
    logic [3:0]  mE_icode, mE_ifun, mE_stat, mE_dstE, mE_dstM, mE_srcA, mE_srcB;
    logic [63:0] mE_valC, mE_valA, mE_valB;

    function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'd4;
        return F;
    endfunction

    function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
        return F;
    endfunction

    function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'd4;
        return F;
    endfunction

    function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
        return (ic inside {4'h5, 4'hB}) ? ra : F;
    endfunction

    function automatic logic [63:0] m_opnd(input logic [3:0] s);
        logic [3:0]  dl [5];
        logic [63:0] vl [5];
        if (s == F) return 64'd0;
        dl = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        vl = '{e_valE, m_valM, M_valE, W_valM, W_valE};
`ifdef DECODE_FWD_EN
        for (int i = 0; i < 5; i++) if (dl[i] == s) return vl[i];
`endif
        return mR[s];
    endfunction

    function automatic logic m_loaduse();
        logic [3:0] sa, sb;
        sa = m_srcA(D_icode, D_rA);
        sb = m_srcB(D_icode, D_rB);
        return (mE_icode inside {4'h5, 4'hB}) && mE_dstM != F && (mE_dstM == sa || mE_dstM == sb);
    endfunction

    function automatic logic m_hazard();
        logic [3:0] s [2];
        logic [3:0] b [6];
        logic       hit;
        s = '{m_srcA(D_icode, D_rA), m_srcB(D_icode, D_rB)};
        b = '{mE_dstE, mE_dstM, M_dstE, M_dstM, W_dstE, W_dstM};
        hit = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 6; j++)
                if (s[i] != F && b[j] == s[i]) hit = 1'b1;
`ifdef DECODE_FWD_EN
        hit = 1'b0;
`endif
        return hit;
    endfunction

    // Advance the reference model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [3:0] sa, sb;
        sa = m_srcA(D_icode, D_rA);
        sb = m_srcB(D_icode, D_rB);
        if (!rst_n || E_bubble) begin
            mE_icode = 4'h1; mE_ifun = 4'h0; mE_stat = 4'h8;
            mE_valC = 64'd0; mE_valA = 64'd0; mE_valB = 64'd0;
            mE_dstE = F; mE_dstM = F; mE_srcA = F; mE_srcB = F;
        end else begin
            mE_icode = D_icode; mE_ifun = D_ifun; mE_stat = D_stat; mE_valC = D_valC;
            mE_valA = (D_icode inside {4'h7, 4'h8}) ? D_valP : m_opnd(sa);
            mE_valB = m_opnd(sb);
            mE_dstE = m_dstE(D_icode, D_rB); mE_dstM = m_dstM(D_icode, D_rA);
            mE_srcA = sa; mE_srcB = sb;
        end
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) mR[i] = 64'd0;
        end else if (W_stat == 4'h8) begin
            if (W_dstE != F) mR[W_dstE] = W_valE;
            if (W_dstM != F) mR[W_dstM] = W_valM;
        end
    endtask

    task automatic clk_edge();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        E_bubble = 1'b0;
        D_icode = 4'h1; D_ifun = 4'h0; D_rA = F; D_rB = F; D_stat = 4'h8;
        D_valC = 64'd0; D_valP = 64'd0;
        e_dstE = F; M_dstE = F; M_dstM = F; W_dstE = F; W_dstM = F; W_stat = 4'h8;
        e_valE = 64'd0; M_valE = 64'd0; m_valM = 64'd0; W_valE = 64'd0; W_valM = 64'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        clk_edge();
        n_total++;
        if ({E_icode, E_dstE, E_stat} !== {4'h1, F, 4'h8})
            $display("FAIL reset_bubble: got icode=%h dstE=%h stat=%h want 1 f 8", E_icode, E_dstE, E_stat);
        else n_pass++;
        rst_n = 1'b1;
        clk_edge();
        n_total++;
        if ({E_icode, E_dstM, E_valA} !== {4'h1, F, 64'd0})
            $display("FAIL nop_keeps_bubble: got icode=%h dstM=%h valA=%h", E_icode, E_dstM, E_valA);
        else n_pass++;
        for (int i = 0; i < 15; i++) begin
            D_icode = 4'h6; D_rA = 4'(i); D_rB = 4'(i);
            clk_edge();
            n_total++;
            if ({E_valA, E_valB} !== 128'd0)
                $display("FAIL reset_reg%0d: got %h/%h want 0", i, E_valA, E_valB);
            else n_pass++;
        end
        set_idle();
        clk_edge();
    endtask

    task automatic test_wb_read();
        W_dstE = 4'd3; W_valE = 64'h55;
        clk_edge();
        set_idle();
        D_icode = 4'h6; D_rA = 4'd3; D_rB = 4'd3;
        clk_edge();
        n_total++;
        if ({E_valA, E_valB} !== {64'h55, 64'h55})
            $display("FAIL wb_then_read: got %h/%h want 55/55", E_valA, E_valB);
        else n_pass++;
        // Same-cycle write and read of r3.
        W_dstE = 4'd3; W_valE = 64'h66;
        clk_edge();
        n_total++;
`ifdef DECODE_FWD_EN
        if (E_valA !== 64'h66) $display("FAIL wb_same_cycle: got %h want 66", E_valA);
`else
        if (E_valA !== 64'h55) $display("FAIL wb_same_cycle: got %h want 55", E_valA);
`endif
        else n_pass++;
        set_idle();
        clk_edge();
    endtask

    task automatic test_priority();
        D_icode = 4'h6; D_rA = 4'd2; D_rB = F;
        e_dstE = 4'd2; e_valE = 64'd7; M_dstE = 4'd2; M_valE = 64'd9;
        #1;
        n_total++;
`ifdef DECODE_FWD_EN
        if (d_hazard !== 1'b0) $display("FAIL prio_hazard: got %b want 0", d_hazard);
`else
        if (d_hazard !== 1'b1) $display("FAIL prio_hazard: got %b want 1", d_hazard);
`endif
        else n_pass++;
        clk_edge();
        n_total++;
`ifdef DECODE_FWD_EN
        if (E_valA !== 64'd7) $display("FAIL prio_e_first: got %h want 7", E_valA);
`else
        if (E_valA !== 64'd0) $display("FAIL prio_e_first: got %h want 0", E_valA);
`endif
        else n_pass++;
        e_dstE = F;
        clk_edge();
        n_total++;
`ifdef DECODE_FWD_EN
        if (E_valA !== 64'd9) $display("FAIL prio_m_vale: got %h want 9", E_valA);
`else
        if (E_valA !== 64'd0) $display("FAIL prio_m_vale: got %h want 0", E_valA);
`endif
        else n_pass++;
        M_dstM = 4'd2; m_valM = 64'hA;
        clk_edge();
        n_total++;
`ifdef DECODE_FWD_EN
        if (E_valA !== 64'hA) $display("FAIL prio_m_valm: got %h want a", E_valA);
`else
        if (E_valA !== 64'd0) $display("FAIL prio_m_valm: got %h want 0", E_valA);
`endif
        else n_pass++;
        set_idle();
        clk_edge();
    endtask

    task automatic test_popq();
        W_dstE = 4'd4; W_valE = 64'd1; W_dstM = 4'd4; W_valM = 64'd2;
        clk_edge();
        set_idle();
        D_icode = 4'h6; D_rA = 4'd4;
        clk_edge();
        n_total++;
        if (E_valA !== 64'd2) $display("FAIL popq_m_wins: got %h want 2", E_valA);
        else n_pass++;
        set_idle();
        W_dstE = 4'd4; W_valE = 64'h11; W_stat = 4'h2;
        clk_edge();
        set_idle();
        D_icode = 4'h6; D_rA = 4'd4;
        clk_edge();
        n_total++;
        if (E_valA !== 64'd2) $display("FAIL stat_blocks_wb: got %h want 2", E_valA);
        else n_pass++;
        set_idle();
        clk_edge();
    endtask

    task automatic test_loaduse();
        D_icode = 4'h5; D_rA = 4'd5; D_rB = F;
        clk_edge();
        n_total++;
        if ({E_icode, E_dstM} !== {4'h5, 4'd5})
            $display("FAIL mrmov_in_e: got icode=%h dstM=%h want 5 5", E_icode, E_dstM);
        else n_pass++;
        D_icode = 4'h6; D_rA = 4'd5; D_rB = 4'd1;
        #1;
        n_total++;
        if ({d_loaduse, d_srcA} !== {1'b1, 4'd5})
            $display("FAIL loaduse_set: got lu=%b srcA=%h want 1 5", d_loaduse, d_srcA);
        else n_pass++;
        E_bubble = 1'b1;
        clk_edge();
        n_total++;
        if ({E_icode, E_dstM} !== {4'h1, F})
            $display("FAIL bubble_load: got icode=%h dstM=%h want 1 f", E_icode, E_dstM);
        else n_pass++;
        E_bubble = 1'b0;
        #1;
        n_total++;
        if (d_loaduse !== 1'b0) $display("FAIL loaduse_clear: got %b want 0", d_loaduse);
        else n_pass++;
        set_idle();
        clk_edge();
    endtask

    task automatic test_stall_and_valp();
        M_dstE = 4'd1; M_valE = 64'hAB;
        D_icode = 4'h6; D_rA = 4'd1; D_rB = F;
        #1;
        n_total++;
`ifdef DECODE_FWD_EN
        if (d_hazard !== 1'b0) $display("FAIL hazard_m_dste: got %b want 0", d_hazard);
`else
        if (d_hazard !== 1'b1) $display("FAIL hazard_m_dste: got %b want 1", d_hazard);
`endif
        else n_pass++;
        clk_edge();
        n_total++;
`ifdef DECODE_FWD_EN
        if (E_valA !== 64'hAB) $display("FAIL hazard_vala: got %h want ab", E_valA);
`else
        if (E_valA !== 64'd0) $display("FAIL hazard_vala: got %h want 0", E_valA);
`endif
        else n_pass++;
        D_icode = 4'h7; D_valP = 64'h1234;
        #1;
        n_total++;
        if (d_hazard !== 1'b0) $display("FAIL jxx_no_hazard: got %b want 0", d_hazard);
        else n_pass++;
        clk_edge();
        n_total++;
        if ({E_valA, E_srcA} !== {64'h1234, F})
            $display("FAIL jxx_valp: got valA=%h srcA=%h want 1234 f", E_valA, E_srcA);
        else n_pass++;
        set_idle();
        clk_edge();
    endtask

    function automatic logic [3:0] rnd_reg();
        int r;
        r = int'($urandom_range(0, 7));
        return (r == 7) ? F : 4'(r);
    endfunction

    function automatic logic [3:0] rnd_stat();
        case ($urandom_range(0, 5))
            0: return 4'h4;
            1: return 4'h2;
            2: return 4'h1;
            default: return 4'h8;
        endcase
    endfunction

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            E_bubble = ($urandom_range(0, 7) == 0);
            D_icode = 4'($urandom_range(0, 15)); D_ifun = 4'($urandom_range(0, 15));
            D_rA = rnd_reg(); D_rB = rnd_reg(); D_stat = rnd_stat();
            D_valC = {$urandom, $urandom}; D_valP = {$urandom, $urandom};
            e_dstE = rnd_reg(); M_dstE = rnd_reg(); M_dstM = rnd_reg();
            W_dstE = rnd_reg(); W_dstM = rnd_reg(); W_stat = rnd_stat();
            e_valE = {$urandom, $urandom}; M_valE = {$urandom, $urandom};
            m_valM = {$urandom, $urandom}; W_valE = {$urandom, $urandom};
            W_valM = {$urandom, $urandom};
            #1;
            n_total++;
            if ({d_srcA, d_srcB, d_loaduse, d_hazard} !==
                {m_srcA(D_icode, D_rA), m_srcB(D_icode, D_rB), m_loaduse(), m_hazard()})
                $display("FAIL rnd_comb[%0d]: got srcA=%h srcB=%h lu=%b hz=%b want %h %h %b %b", n,
                         d_srcA, d_srcB, d_loaduse, d_hazard, m_srcA(D_icode, D_rA),
                         m_srcB(D_icode, D_rB), m_loaduse(), m_hazard());
            else n_pass++;
            clk_edge();
            n_total++;
            if ({E_icode, E_ifun, E_stat, E_dstE, E_dstM, E_srcA, E_srcB} !==
                {mE_icode, mE_ifun, mE_stat, mE_dstE, mE_dstM, mE_srcA, mE_srcB})
                $display("FAIL rnd_ctrl[%0d]: got %h%h%h%h%h%h%h want %h%h%h%h%h%h%h", n,
                         E_icode, E_ifun, E_stat, E_dstE, E_dstM, E_srcA, E_srcB,
                         mE_icode, mE_ifun, mE_stat, mE_dstE, mE_dstM, mE_srcA, mE_srcB);
            else n_pass++;
            n_total++;
            if ({E_valC, E_valA, E_valB} !== {mE_valC, mE_valA, mE_valB})
                $display("FAIL rnd_vals[%0d]: got %h %h %h want %h %h %h", n,
                         E_valC, E_valA, E_valB, mE_valC, mE_valA, mE_valB);
            else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_wb_read();
        test_priority();
        test_popq();
        test_loaduse();
        test_stall_and_valp();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
